// File: rtl/piso_ser_pkg.sv
// Shared widths for the LSTM serial datapath, so the parallel bus of this
// converter matches the vector produced upstream.
package piso_ser_pkg;
    localparam int WORD_WIDTH = 32;
    localparam int LSTM_NUM   = 68;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/piso_cnt.sv
// Word index counter: clear has priority over enable; tc flags the final
// word index (NUM-1).
module piso_cnt
    import piso_ser_pkg::*;
#(
    parameter int NUM = LSTM_NUM,
    parameter int CW  = idx_width(NUM)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          tc
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CW'(1);
        end
    end

    assign tc = (count == CW'(NUM - 1));
endmodule

// File: rtl/piso_ser.sv
// Parallel-in serial-out converter: takes a NUM-word vector in one handshake
// and streams it out LSB word first on a valid/ready interface.
module piso_ser
    import piso_ser_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH,
    parameter int NUM   = LSTM_NUM,
    parameter int CW    = idx_width(NUM)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM*WIDTH-1:0] i,
    input  logic                 i_valid,
    output logic                 i_ready,
    output logic [WIDTH-1:0]     o,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic                 o_last,
    output logic [CW-1:0]        o_idx
);
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [NUM*WIDTH-1:0] d;
    logic                 load;
    logic                 xfer;
    logic                 last_xfer;
    logic                 tc;

    assign xfer      = o_valid && o_ready;
    assign last_xfer = xfer && o_last;
    assign i_ready   = (state == IDLE) || last_xfer;
    assign load      = i_valid && i_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load) state_next = SHIFT;
            SHIFT:   if (last_xfer && !load) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The output word is the bottom of d; the final word is never shifted out
    // so o keeps its last value once the vector has drained.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d       <= '0;
            o_valid <= 1'b0;
        end else if (load) begin
            d       <= i;
            o_valid <= 1'b1;
        end else if (xfer) begin
            if (o_last) begin
                o_valid <= 1'b0;
            end else begin
                d <= d >> WIDTH;
            end
        end
    end

    assign o = d[WIDTH-1:0];

    piso_cnt #(
        .NUM(NUM),
        .CW (CW)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (load || last_xfer),
        .en   (xfer && !o_last),
        .count(o_idx),
        .tc   (tc)
    );

    // The counter sits at 0 while idle, so gate tc to keep o_last low then.
    assign o_last = o_valid && tc;
endmodule

// File: tb/tb_piso_ser.sv
// Self-checking bench for piso_ser: directed tables, hand-written corner
// sequences and a randomized run against a queue-based reference model.
module tb_piso_ser;
    import piso_ser_pkg::*;

    logic         clk;
    logic         rst;
    logic [127:0] i;
    logic         i_valid;
    logic         i_ready;
    logic [31:0]  o;
    logic         o_valid;
    logic         o_ready;
    logic         o_last;
    logic [1:0]   o_idx;

    logic [31:0]  i1;
    logic         i1_valid;
    logic         i1_ready;
    logic [31:0]  o1;
    logic         o1_valid;
    logic         o1_ready;
    logic         o1_last;
    logic [0:0]   o1_idx;

    int vectors;
    int miscompares;

    typedef struct packed {
        logic        iv;
        logic        ordy;
        logic        ev;
        logic [31:0] eo;
        logic [1:0]  eidx;
        logic        el;
        logic        eir;
    } vec_t;

    typedef struct {
        logic [31:0] w;
        int          idx;
        logic        last;
    } word_t;

    vec_t  tbl[$];
    word_t model[$];

    piso_ser #(.WIDTH(32), .NUM(4)) dut (
        .clk(clk), .rst(rst), .i(i), .i_valid(i_valid), .i_ready(i_ready),
        .o(o), .o_valid(o_valid), .o_ready(o_ready), .o_last(o_last), .o_idx(o_idx)
    );

    piso_ser #(.WIDTH(32), .NUM(1)) dut1 (
        .clk(clk), .rst(rst), .i(i1), .i_valid(i1_valid), .i_ready(i1_ready),
        .o(o1), .o_valid(o1_valid), .o_ready(o1_ready), .o_last(o1_last), .o_idx(o1_idx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t row(logic iv, logic ordy, logic ev, logic [31:0] eo,
                                 logic [1:0] eidx, logic el, logic eir);
        vec_t r;
        r.iv = iv; r.ordy = ordy; r.ev = ev; r.eo = eo;
        r.eidx = eidx; r.el = el; r.eir = eir;
        return r;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input string tag, input logic ev, input logic [31:0] eo,
                               input logic [1:0] eidx, input logic el, input logic eir);
        checkVal({tag, ".o_valid"}, 32'(o_valid), 32'(ev));
        if (ev) checkVal({tag, ".o"}, o, eo);
        checkVal({tag, ".o_idx"}, 32'(o_idx), 32'(eidx));
        checkVal({tag, ".o_last"}, 32'(o_last), 32'(el));
        checkVal({tag, ".i_ready"}, 32'(i_ready), 32'(eir));
    endtask

    task automatic applyStimulus(input logic iv, input logic ordy);
        i_valid = iv;
        o_ready = ordy;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [127:0] v1;
        logic [127:0] v2;
        logic [127:0] v3;
        logic         exp_ir;
        vectors     = 0;
        miscompares = 0;
        v1 = {32'h4, 32'h3, 32'h2, 32'h1};
        v2 = {32'h8, 32'h7, 32'h6, 32'h5};
        v3 = {32'hD, 32'hC, 32'hB, 32'hA};
        rst = 1'b1; i = '0; i_valid = 1'b0; o_ready = 1'b0;
        i1 = '0; i1_valid = 1'b0; o1_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        step();

        // Basic serialization then backpressure with stalls on output cycles 2-4.
        tbl.push_back(row(1, 1, 0, 32'h0, 0, 0, 1));
        tbl.push_back(row(0, 1, 1, 32'h1, 0, 0, 0));
        tbl.push_back(row(0, 1, 1, 32'h2, 1, 0, 0));
        tbl.push_back(row(0, 1, 1, 32'h3, 2, 0, 0));
        tbl.push_back(row(0, 1, 1, 32'h4, 3, 1, 1));
        tbl.push_back(row(0, 1, 0, 32'h0, 0, 0, 1));
        tbl.push_back(row(1, 1, 0, 32'h0, 0, 0, 1));
        tbl.push_back(row(0, 1, 1, 32'h1, 0, 0, 0));
        tbl.push_back(row(0, 0, 1, 32'h2, 1, 0, 0));
        tbl.push_back(row(0, 0, 1, 32'h2, 1, 0, 0));
        tbl.push_back(row(0, 0, 1, 32'h2, 1, 0, 0));
        tbl.push_back(row(0, 1, 1, 32'h2, 1, 0, 0));
        tbl.push_back(row(0, 1, 1, 32'h3, 2, 0, 0));
        tbl.push_back(row(0, 1, 1, 32'h4, 3, 1, 1));
        tbl.push_back(row(0, 1, 0, 32'h0, 0, 0, 1));
        i = v1;
        for (int r = 0; r < tbl.size(); r++) begin
            applyStimulus(tbl[r].iv, tbl[r].ordy);
            checkOutput($sformatf("tbl%0d", r), tbl[r].ev, tbl[r].eo, tbl[r].eidx,
                        tbl[r].el, tbl[r].eir);
            step();
        end

        // Back-to-back: second vector loads while word 0x4 transfers.
        i = v1;
        applyStimulus(1, 1);
        step();
        for (int j = 0; j < 8; j++) begin
            if (j == 3) i = v2;
            applyStimulus(j == 3, 1);
            checkOutput($sformatf("b2b%0d", j), 1, 32'(j + 1), 2'(j % 4), (j % 4) == 3,
                        (j == 3) || (j == 7));
            step();
        end
        applyStimulus(0, 1);
        checkOutput("b2b_end", 0, 32'h0, 0, 0, 1);

        // Reset mid-vector after word 0x2 is on the output.
        i = v1;
        applyStimulus(1, 1);
        step();
        applyStimulus(0, 1);
        checkOutput("rm_w1", 1, 32'h1, 0, 0, 0);
        step();
        applyStimulus(0, 1);
        checkOutput("rm_w2", 1, 32'h2, 1, 0, 0);
        #1 rst = 1'b1;
        #1;
        checkOutput("rm_async", 0, 32'h0, 0, 0, 1);
        checkVal("rm_async.o", o, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        step();
        applyStimulus(0, 0);
        checkOutput("rst_vals", 0, 32'h0, 0, 0, 1);
        checkVal("rst_vals.o", o, 32'h0);
        i = v3;
        applyStimulus(1, 1);
        step();
        for (int j = 0; j < 4; j++) begin
            applyStimulus(0, 1);
            checkOutput($sformatf("rm_re%0d", j), 1, 32'hA + 32'(j), 2'(j), j == 3, j == 3);
            step();
        end

        // NUM = 1: each load is a single last word; reload while it transfers.
        i1 = 32'hDEADBEEF; i1_valid = 1'b1; o1_ready = 1'b1;
        #1 checkVal("n1_idle.i_ready", 32'(i1_ready), 32'h1);
        step();
        i1_valid = 1'b0;
        #1;
        checkVal("n1.o_valid", 32'(o1_valid), 32'h1);
        checkVal("n1.o", o1, 32'hDEADBEEF);
        checkVal("n1.o_last", 32'(o1_last), 32'h1);
        checkVal("n1.o_idx", 32'(o1_idx), 32'h0);
        checkVal("n1.i_ready", 32'(i1_ready), 32'h1);
        i1_valid = 1'b1; o1_ready = 1'b0;
        step();
        i1 = 32'h12345678;
        #1 checkVal("n1_stall.i_ready", 32'(i1_ready), 32'h0);
        o1_ready = 1'b1;
        #1 checkVal("n1_last.i_ready", 32'(i1_ready), 32'h1);
        step();
        i1_valid = 1'b0;
        #1;
        checkVal("n1_reload.o", o1, 32'h12345678);
        checkVal("n1_reload.o_valid", 32'(o1_valid), 32'h1);
        checkVal("n1_reload.o_last", 32'(o1_last), 32'h1);
        step();
        #1 checkVal("n1_done.o_valid", 32'(o1_valid), 32'h0);

        // Randomized traffic against a queue of outstanding words.
        model.delete();
        for (int c = 0; c < 400; c++) begin
            logic iv;
            logic ordy;
            iv   = ($urandom_range(0, 2) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            i = {$urandom, $urandom, $urandom, $urandom};
            applyStimulus(iv, ordy);
            exp_ir = (model.size() == 0) || (ordy && model.size() == 1);
            if (model.size() > 0) begin
                checkOutput($sformatf("rnd%0d", c), 1, model[0].w, 2'(model[0].idx),
                            model[0].last, exp_ir);
            end else begin
                checkOutput($sformatf("rnd%0d", c), 0, 32'h0, 0, 0, exp_ir);
            end
            if (model.size() > 0 && ordy) void'(model.pop_front());
            if (iv && exp_ir) begin
                for (int k = 0; k < 4; k++) begin
                    word_t wd;
                    wd.w    = i[k*32 +: 32];
                    wd.idx  = k;
                    wd.last = (k == 3);
                    model.push_back(wd);
                end
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/piso_ser.md
# piso_ser

Parallel-in serial-out converter for the LSTM datapath. It accepts one NUM-word vector, such as a completed h_t or gate-output bundle, in a single handshake. It then emits the words one per cycle, LSB word first, on a valid/ready stream for writeback memory or the next serial stage. It is the transmit-side counterpart of the serial-in parallel-out input path.

## Interface
- WIDTH, 32: bits per word (Q-format fixed point, treated as opaque bits).
- NUM, 68: words per vector; any NUM >= 1 is legal.
- CW, $clog2(NUM) (min 1): width of the word index.

- clk  input  1: single clock; all state updates on the rising edge.
- rst  input  1: asynchronous, active-high reset.
- i  input  NUM*WIDTH: parallel vector; word k = i[k*WIDTH +: WIDTH].
- i_valid  input  1: i holds a vector to transfer.
- i_ready  output  1: block can capture i this cycle (combinational).
- o  output  WIDTH: current serial word (registered).
- o_valid  output  1: o is valid (registered).
- o_ready  input  1: downstream accepts o this cycle.
- o_last  output  1: o is word NUM-1 of the vector (registered).
- o_idx  output  CW: index of the current word (registered).

## Operation
- The FSM has two states, IDLE and SHIFT.
- Input handshake: a load happens when i_valid && i_ready. Output handshake: a word transfers when o_valid && o_ready.
- i_ready = (state==IDLE) || (o_valid && o_ready && o_last). This allows a new vector to load in the same cycle the last word of the previous one transfers.
- IDLE:
  - o_valid = 0.
  - On a load: capture i into data register D, set o = i[WIDTH-1:0], o_idx = 0, o_last = (NUM==1), o_valid = 1, then go to SHIFT.
- SHIFT, transfer of a non-last word:
  - D shifts right by WIDTH (zero fill).
  - o takes the next word, o_idx increments, and o_last = (o_idx+1 == NUM-1).
- SHIFT, transfer of the last word:
  - If a load happens the same cycle, reload exactly as from IDLE and stay in SHIFT.
  - Otherwise clear o_valid and o_last, set o_idx = 0, and go to IDLE. o keeps its last value, which is don't-care while o_valid = 0.
- SHIFT, no transfer (o_ready = 0): o, o_idx, o_last and o_valid hold unchanged. This is a stall of any length.
- Words are never dropped, duplicated or reordered. Exactly NUM transfers occur per load, and o_last is asserted on exactly the final one.
- i is sampled only on a load. Changes to i at any other time have no effect.
- Reset, asynchronous and allowed at any time:
  - state = IDLE; D, o, o_idx, o_valid and o_last = 0.
  - A partially sent vector is discarded. The first cycle after rst deasserts shows i_ready = 1.

## Timing
- Load at edge k: the first word is on o with o_valid = 1 in the cycle after edge k (latency 1).
- With o_ready held high, word j transfers at edge k+1+j. The last word transfers at edge k+NUM.
- Back-to-back vectors run at NUM cycles per vector with no bubble. The worst case, when the next load is not coincident with the last word, is NUM+1 cycles.
- i_ready has a combinational path from o_ready. o, o_valid, o_last and o_idx have no combinational path from any input.

## Structure
- A shared package or include holds the codebase default WIDTH = 32 and the vector-length constant used by the LSTM top, so the parallel width matches the producer.
- State encoding is local localparams: IDLE = 1'b0, SHIFT = 1'b1.
- One sub-module is natural: piso_cnt. It is a CW-bit word counter with clear, enable and a terminal-count flag (count == NUM-1) that drives o_last. The data shift register stays inline.

## Test plan
Bench configuration: WIDTH = 32, NUM = 4 unless stated.
1. Reset values: assert rst mid-run, then release -> o_valid = 0, o_last = 0, o_idx = 0, o = 0, i_ready = 1.
2. Basic serialization: i = {0x4,0x3,0x2,0x1}, i_valid for one cycle, o_ready = 1 -> o = 0x1, 0x2, 0x3, 0x4 on 4 consecutive cycles, o_idx = 0..3, o_last only on 0x4, then i_ready = 1.
3. Backpressure: same vector with o_ready low on cycles 2-4 of output -> o holds 0x2 with o_idx = 1 while stalled; sequence is still 0x1..0x4; i_ready stays 0.
4. Back-to-back: second vector {0x8,0x7,0x6,0x5} presented while word 0x4 transfers -> 8 consecutive valid cycles 0x1..0x8 with no bubble; o_last on 0x4 and 0x8.
5. Reset mid-vector: rst after word 0x2 -> o_valid drops asynchronously; the next load of {0xD,0xC,0xB,0xA} outputs 0xA first with o_idx = 0.
6. NUM = 1: i = 0xDEADBEEF -> one word with o_last = 1 and o_idx = 0; i_ready = 1 in the same cycle it transfers.
